// File: rtl/trace_monitor.sv
// Cycle-accurate trace capture: samples PC plus watched registers each run cycle into a
// record FIFO and serialises each record as CH+1 words over a valid/ready read port.
module trace_monitor #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CH          = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CYCLE_LIMIT = 30
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     clear_i,
  input  logic [DATA_W-1:0]        pc_i,
  input  logic [CH*DATA_W-1:0]     reg_i,
  input  logic                     rd_ready_i,
  output logic                     rd_valid_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_last_o,
  output logic                     halt_o,
  output logic [31:0]              cycle_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned WORDS = CH + 1;
  localparam int unsigned IW    = $clog2(WORDS);
  localparam int unsigned RecW  = WORDS * DATA_W;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e            state_q, state_d;
  logic [RecW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [IW-1:0]     widx_q, widx_d;
  logic [31:0]       cycle_q, cycle_d;
  logic              ovf_q, ovf_d;

  logic              capture, wr_en, accept, pop;
  logic [RecW-1:0]   rd_rec;
  logic [DATA_W-1:0] rd_words [WORDS];

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; halting is decided on the edge that captures sample CYCLE_LIMIT
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (start_i) state_d = StRun;
        StRun: begin
          if (!start_i) state_d = StIdle;
          else if (CYCLE_LIMIT != 0 && cycle_d == 32'(CYCLE_LIMIT)) state_d = StHalt;
        end
        StHalt:  state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    capture = (state_q == StRun) && start_i && !clear_i;
    halt_o  = (state_q == StHalt);
  end

  // Read side
  always_comb begin
    rd_rec = mem_q[rd_ptr_q];
    for (int k = 0; k < WORDS; k++) rd_words[k] = rd_rec[k*DATA_W +: DATA_W];
    rd_valid_o = (level_q != '0);
    rd_last_o  = rd_valid_o && (widx_q == IW'(CH));
    rd_data_o  = rd_valid_o ? rd_words[widx_q] : '0;
    accept     = rd_valid_o && rd_ready_i;
    pop        = accept && rd_last_o;
    // A full buffer still accepts a record when the head is popped on the same edge
    wr_en      = capture && ((level_q != LW'(DEPTH)) || pop);
  end

  // Datapath next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    widx_d   = widx_q;
    cycle_d  = cycle_q;
    ovf_d    = ovf_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      widx_d   = '0;
      cycle_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (capture) cycle_d = cycle_q + 32'd1;
      if (capture && !wr_en) ovf_d = 1'b1;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (accept) widx_d = pop ? '0 : widx_q + IW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en && !pop) level_d = level_q + LW'(1);
      else if (pop && !wr_en) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      widx_q   <= '0;
      cycle_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      widx_q   <= widx_d;
      cycle_q  <= cycle_d;
      ovf_q    <= ovf_d;
    end
  end

  // Record storage needs no reset; read data is gated by rd_valid_o
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= {reg_i, pc_i};
  end

  assign cycle_o    = cycle_q;
  assign overflow_o = ovf_q;
  assign level_o    = level_q;

endmodule
